fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Fetch-stage front end: owns the fetch PC, drives it to the 5-byte-wide
//  combinational instruction memory and captures each returned 40-bit
//  instruction, with its PC, into a small FIFO. The FIFO feeds decode over a
//  valid/ready handshake and decouples decode stalls from fetch. A redirect
//  from execute (branch/jump) flushes the queue and reloads the PC.
// PARAMETERS
//  DEPTH       4      queue entries; power of two, >= 2
//  INSTR_BYTES 5      fixed PC increment per fetched instruction
//  RESET_PC    32'h0  fetch PC value after reset
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  rst_n          in   1   asynchronous active-low reset
//  fetch_en       in   1   1 = fetch may enqueue this cycle
//  imem_pc        out  32  byte address to instruction memory (= fetch_pc)
//  imem_instr     in   40  instruction bytes at imem_pc, same cycle
//  redirect_valid in   1   flush queue and load redirect_pc
//  redirect_pc    in   32  new fetch PC
//  dec_valid      out  1   head entry valid
//  dec_ready      in   1   decode accepts head entry
//  dec_instr      out  40  head entry instruction
//  dec_pc         out  32  head entry PC
//  q_count        out  clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Reset (async assert, sync release): fetch_pc=RESET_PC, wr/rd ptr=0,
//    q_count=0, dec_valid=0, dec_instr=0, dec_pc=0.
//  - imem_pc is fetch_pc directly (register output, no comb path from inputs).
//  - deq = dec_valid & dec_ready.
//  - enq = fetch_en & ~redirect_valid & (q_count<DEPTH | deq); full queue with
//    a same-cycle dequeue accepts an enqueue.
//  - On enq: entry[wr_ptr] <= {imem_instr, fetch_pc}; wr_ptr++;
//    fetch_pc <= fetch_pc + INSTR_BYTES (mod 2^32, wraps silently).
//  - No enq: fetch_pc holds (redirect excepted).
//  - Latency: instr fetched in cycle N visible on dec_* in cycle N+1 if queue
//    was empty, i.e. one cycle PC-to-decode.
//  - dec_valid = (q_count != 0); dec_instr/dec_pc = entry[rd_ptr]; zero when
//    empty. On deq: rd_ptr++.
//  - q_count: +1 on enq only, -1 on deq only, unchanged on both.
//  - Pointers are log2(DEPTH) bits and wrap naturally.
//  - redirect_valid (highest priority): next cycle q_count=0, wr/rd ptr=0,
//    dec_valid=0, fetch_pc=redirect_pc. A deq in the redirect cycle still
//    counts as accepted by decode; no enqueue occurs that cycle. Fetch from
//    redirect_pc begins the following cycle.
//  - Redirect while empty or full: identical flush behaviour.
//  - fetch_en=0: no enqueue, queue drains normally via deq.
//  - Reset mid-operation: all state returns to reset values immediately.
//  - dec_instr/dec_pc stable while dec_valid=1 and dec_ready=0.
// TESTING
//  1 Reset, fetch_en=1, dec_ready=1, imem returns 40'hAA00000001 @0 ->
//    imem_pc 0,5,10,...; dec_pc=0 with dec_instr=40'hAA00000001 in cycle 2.
//  2 dec_ready=0, DEPTH=4 -> q_count 1..4, imem_pc holds at 20, dec_pc
//    stays 0; raise dec_ready -> one deq+enq per cycle, q_count stays 4.
//  3 Queue holds PCs 5,10,15; redirect_valid=1, redirect_pc=32'h40 ->
//    next cycle dec_valid=0, q_count=0, imem_pc=0x40; then dec_pc=0x40.
//  4 Redirect with dec_valid=1,dec_ready=1 same cycle -> head consumed, no
//    enqueue, queue empty next cycle.
//  5 redirect_pc=32'hFFFFFFFE, fetch 2 instrs -> dec_pc FFFFFFFE then
//    00000003 (wrap).
//  6 rst_n low mid-stream with q_count=3 -> q_count=0, dec_valid=0,
//    imem_pc=RESET_PC without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction-memory port, execute redirect and the decode handshake.
// The slave modport belongs to the fetch queue; master is the surrounding pipeline.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             fetch_en;
    logic [31:0]      imem_pc;
    logic [39:0]      imem_instr;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             dec_valid;
    logic             dec_ready;
    logic [39:0]      dec_instr;
    logic [31:0]      dec_pc;
    logic [CNT_W-1:0] q_count;

    modport master (
        output fetch_en, imem_instr, redirect_valid, redirect_pc, dec_ready,
        input  imem_pc, dec_valid, dec_instr, dec_pc, q_count
    );

    modport slave (
        input  fetch_en, imem_instr, redirect_valid, redirect_pc, dec_ready,
        output imem_pc, dec_valid, dec_instr, dec_pc, q_count
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch-stage front end: owns the fetch PC, captures {instr, pc} from imem into a
// small FIFO feeding decode, and flushes/reloads on an execute redirect.
module fetch_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned INSTR_BYTES = 5,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [39:0]      instr_q [DEPTH];
    logic [39:0]      instr_d [DEPTH];
    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      pc_d    [DEPTH];
    logic             dec_valid_q, dec_valid_d;
    logic [39:0]      dec_instr_q, dec_instr_d;
    logic [31:0]      dec_pc_q, dec_pc_d;
    logic             deq;
    logic             enq;

    // Next-state: redirect flushes everything; otherwise enqueue/dequeue independently.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        instr_d    = instr_q;
        pc_d       = pc_q;

        deq = dec_valid_q & bus.dec_ready;
        enq = bus.fetch_en & ~bus.redirect_valid & ((count_q < CNT_W'(DEPTH)) | deq);

        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (enq) begin
                instr_d[wr_ptr_q] = bus.imem_instr;
                pc_d[wr_ptr_q]    = fetch_pc_q;
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
                fetch_pc_d        = fetch_pc_q + 32'(INSTR_BYTES);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (enq && !deq) begin
                count_d = count_q + CNT_W'(1);
            end else if (deq && !enq) begin
                count_d = count_q - CNT_W'(1);
            end
        end

        // Head presented to decode is registered from the next-state view of the queue.
        dec_valid_d = (count_d != '0);
        dec_instr_d = dec_valid_d ? instr_d[rd_ptr_d] : 40'h0;
        dec_pc_d    = dec_valid_d ? pc_d[rd_ptr_d]    : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q  <= RESET_PC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dec_valid_q <= 1'b0;
            dec_instr_q <= 40'h0;
            dec_pc_q    <= 32'h0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_q[i] <= 40'h0;
                pc_q[i]    <= 32'h0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dec_valid_q <= dec_valid_d;
            dec_instr_q <= dec_instr_d;
            dec_pc_q    <= dec_pc_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
        end
    end

    assign bus.imem_pc   = fetch_pc_q;
    assign bus.dec_valid = dec_valid_q;
    assign bus.dec_instr = dec_instr_q;
    assign bus.dec_pc    = dec_pc_q;
    assign bus.q_count   = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: imem model returns {8'hAA, pc+1} for every address.
module tb_fetch_queue;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    fetch_queue_if #(.DEPTH(4)) bus ();

    fetch_queue #(
        .DEPTH      (4),
        .INSTR_BYTES(5),
        .RESET_PC   (32'h0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    assign bus.imem_instr = {8'hAA, bus.imem_pc + 32'd1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        bus.fetch_en       = 1'b0;
        bus.dec_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.imem_pc !== 32'h0) begin n_mis++; $display("FAIL reset_imem_pc got %h want %h", bus.imem_pc, 32'h0); end
        n_cmp++; if (bus.dec_valid !== 1'b0) begin n_mis++; $display("FAIL reset_dec_valid got %b want 0", bus.dec_valid); end
        n_cmp++; if (bus.q_count !== 3'd0) begin n_mis++; $display("FAIL reset_q_count got %0d want 0", bus.q_count); end
        n_cmp++; if (bus.dec_instr !== 40'h0 || bus.dec_pc !== 32'h0) begin n_mis++; $display("FAIL reset_dec_bus got %h/%h want 0/0", bus.dec_instr, bus.dec_pc); end
    endtask

    task automatic test_stream();
        do_reset();
        bus.fetch_en  = 1'b1;
        bus.dec_ready = 1'b1;
        step();
        n_cmp++; if (bus.imem_pc !== 32'd5) begin n_mis++; $display("FAIL stream_pc1 got %0d want 5", bus.imem_pc); end
        n_cmp++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'd0) begin n_mis++; $display("FAIL stream_first_dec got v=%b pc=%0d want v=1 pc=0", bus.dec_valid, bus.dec_pc); end
        n_cmp++; if (bus.dec_instr !== 40'hAA00000001) begin n_mis++; $display("FAIL stream_first_instr got %h want AA00000001", bus.dec_instr); end
        for (int i = 1; i <= 3; i++) begin
            step();
            n_cmp++; if (bus.imem_pc !== 32'(5 * (i + 1)) || bus.dec_pc !== 32'(5 * i) || bus.q_count !== 3'd1)
                begin n_mis++; $display("FAIL stream_cycle%0d got pc=%0d dec_pc=%0d cnt=%0d want %0d/%0d/1", i, bus.imem_pc, bus.dec_pc, bus.q_count, 5 * (i + 1), 5 * i); end
        end
    endtask

    task automatic test_fill_stall();
        do_reset();
        bus.fetch_en  = 1'b1;
        bus.dec_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            n_cmp++; if (bus.q_count !== 3'((i > 4) ? 4 : i) || bus.imem_pc !== 32'(5 * ((i > 4) ? 4 : i)) || bus.dec_pc !== 32'd0)
                begin n_mis++; $display("FAIL fill_cycle%0d got cnt=%0d pc=%0d dec_pc=%0d", i, bus.q_count, bus.imem_pc, bus.dec_pc); end
        end
        bus.dec_ready = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            step();
            n_cmp++; if (bus.q_count !== 3'd4 || bus.imem_pc !== 32'(20 + 5 * i) || bus.dec_pc !== 32'(5 * i))
                begin n_mis++; $display("FAIL full_flow%0d got cnt=%0d pc=%0d dec_pc=%0d want 4/%0d/%0d", i, bus.q_count, bus.imem_pc, bus.dec_pc, 20 + 5 * i, 5 * i); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        bus.fetch_en  = 1'b1;
        bus.dec_ready = 1'b0;
        repeat (4) step();
        bus.fetch_en  = 1'b0;
        bus.dec_ready = 1'b1;
        step();
        n_cmp++; if (bus.q_count !== 3'd3 || bus.dec_pc !== 32'd5 || bus.imem_pc !== 32'd20)
            begin n_mis++; $display("FAIL drain_no_fetch got cnt=%0d dec_pc=%0d pc=%0d want 3/5/20", bus.q_count, bus.dec_pc, bus.imem_pc); end
        bus.dec_ready      = 1'b0;
        bus.fetch_en       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        step();
        bus.redirect_valid = 1'b0;
        n_cmp++; if (bus.dec_valid !== 1'b0 || bus.q_count !== 3'd0 || bus.imem_pc !== 32'h40)
            begin n_mis++; $display("FAIL redirect_flush got v=%b cnt=%0d pc=%h want 0/0/40", bus.dec_valid, bus.q_count, bus.imem_pc); end
        step();
        n_cmp++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h40 || bus.dec_instr !== 40'hAA00000041 || bus.imem_pc !== 32'h45)
            begin n_mis++; $display("FAIL redirect_refetch got v=%b dec_pc=%h instr=%h pc=%h want 1/40/AA00000041/45", bus.dec_valid, bus.dec_pc, bus.dec_instr, bus.imem_pc); end
    endtask

    task automatic test_redirect_deq();
        do_reset();
        bus.fetch_en  = 1'b1;
        bus.dec_ready = 1'b0;
        repeat (2) step();
        bus.dec_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        step();
        n_cmp++; if (bus.dec_valid !== 1'b0 || bus.q_count !== 3'd0 || bus.imem_pc !== 32'h100 || bus.dec_pc !== 32'h0)
            begin n_mis++; $display("FAIL redirect_with_deq got v=%b cnt=%0d pc=%h dec_pc=%h want 0/0/100/0", bus.dec_valid, bus.q_count, bus.imem_pc, bus.dec_pc); end
        bus.redirect_valid = 1'b0;
        bus.dec_ready      = 1'b0;
        repeat (5) step();
        n_cmp++; if (bus.q_count !== 3'd4) begin n_mis++; $display("FAIL refill_full got cnt=%0d want 4", bus.q_count); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        step();
        bus.redirect_valid = 1'b0;
        n_cmp++; if (bus.q_count !== 3'd0 || bus.dec_valid !== 1'b0 || bus.imem_pc !== 32'h200)
            begin n_mis++; $display("FAIL redirect_full got cnt=%0d v=%b pc=%h want 0/0/200", bus.q_count, bus.dec_valid, bus.imem_pc); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        bus.fetch_en       = 1'b1;
        bus.dec_ready      = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFFFFFE;
        step();
        bus.redirect_valid = 1'b0;
        n_cmp++; if (bus.imem_pc !== 32'hFFFFFFFE) begin n_mis++; $display("FAIL wrap_redirect_pc got %h want FFFFFFFE", bus.imem_pc); end
        step();
        n_cmp++; if (bus.dec_pc !== 32'hFFFFFFFE || bus.dec_instr !== 40'hAAFFFFFFFF || bus.imem_pc !== 32'h3)
            begin n_mis++; $display("FAIL wrap_first got dec_pc=%h instr=%h pc=%h want FFFFFFFE/AAFFFFFFFF/3", bus.dec_pc, bus.dec_instr, bus.imem_pc); end
        step();
        n_cmp++; if (bus.q_count !== 3'd2 || bus.dec_pc !== 32'hFFFFFFFE)
            begin n_mis++; $display("FAIL wrap_stall_hold got cnt=%0d dec_pc=%h want 2/FFFFFFFE", bus.q_count, bus.dec_pc); end
        bus.fetch_en  = 1'b0;
        bus.dec_ready = 1'b1;
        step();
        n_cmp++; if (bus.dec_pc !== 32'h3 || bus.dec_instr !== 40'hAA00000004 || bus.q_count !== 3'd1)
            begin n_mis++; $display("FAIL wrap_second got dec_pc=%h instr=%h cnt=%0d want 3/AA00000004/1", bus.dec_pc, bus.dec_instr, bus.q_count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.fetch_en  = 1'b1;
        bus.dec_ready = 1'b0;
        repeat (3) step();
        n_cmp++; if (bus.q_count !== 3'd3 || bus.imem_pc !== 32'd15)
            begin n_mis++; $display("FAIL pre_reset got cnt=%0d pc=%0d want 3/15", bus.q_count, bus.imem_pc); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.q_count !== 3'd0 || bus.dec_valid !== 1'b0 || bus.imem_pc !== 32'h0)
            begin n_mis++; $display("FAIL async_reset got cnt=%0d v=%b pc=%h want 0/0/0", bus.q_count, bus.dec_valid, bus.imem_pc); end
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst_n = 1'b0;
        test_reset();
        test_stream();
        test_fill_stall();
        test_redirect();
        test_redirect_deq();
        test_pc_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
